// File: rtl/sample_iterator_pkg.sv
// Shared raster definitions for the sample iterator: FSM states, MSAA mode
// encodings and the per-mode sample step.
package sample_iterator_pkg;

    typedef enum logic [0:0] {
        WAIT_STATE,
        TEST_STATE
    } state_e;

    localparam logic [3:0] SUBSAMP_1X  = 4'b1000;
    localparam logic [3:0] SUBSAMP_4X  = 4'b0100;
    localparam logic [3:0] SUBSAMP_16X = 4'b0010;
    localparam logic [3:0] SUBSAMP_64X = 4'b0001;

    // Grid pitch in fixed point; anything not one-hot falls back to 1x.
    function automatic logic [31:0] subsample_step(input logic [3:0] mode,
                                                   input int unsigned radix);
        logic [31:0] step;
        case (mode)
            SUBSAMP_4X:  step = 32'd1 << (radix - 1);
            SUBSAMP_16X: step = 32'd1 << (radix - 2);
            SUBSAMP_64X: step = 32'd1 << (radix - 3);
            default:     step = 32'd1 << radix;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/sample_stepper.sv
// Raster-order sample walker: holds the current (x,y) and the box limits,
// flags the final sample and computes the next position.
module sample_stepper #(
    parameter int unsigned SIGFIG = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_i,
    input  logic                         advance_i,
    input  logic [1:0][1:0][SIGFIG-1:0] box_i,
    input  logic [SIGFIG-1:0]            step_i,
    output logic [1:0][SIGFIG-1:0]       sample_o,
    output logic                         last_o
);

    logic signed [SIGFIG-1:0] x_q, x_d;
    logic signed [SIGFIG-1:0] y_q, y_d;
    logic signed [SIGFIG-1:0] llx_q, llx_d;
    logic signed [SIGFIG-1:0] urx_q, urx_d;
    logic signed [SIGFIG-1:0] ury_q, ury_d;

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        llx_d = llx_q;
        urx_d = urx_q;
        ury_d = ury_q;
        if (load_i) begin
            x_d   = box_i[0][0];
            y_d   = box_i[0][1];
            llx_d = box_i[0][0];
            urx_d = box_i[1][0];
            ury_d = box_i[1][1];
        end else if (advance_i) begin
            // Signed compares: boxes may sit left of / below the origin.
            if (x_q < urx_q) begin
                x_d = x_q + step_i;
            end else if (y_q < ury_q) begin
                x_d = llx_q;
                y_d = y_q + step_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q   <= '0;
            y_q   <= '0;
            llx_q <= '0;
            urx_q <= '0;
            ury_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            llx_q <= llx_d;
            urx_q <= urx_d;
            ury_q <= ury_d;
        end
    end

    assign sample_o[0] = x_q;
    assign sample_o[1] = y_q;
    assign last_o      = (x_q == urx_q) && (y_q == ury_q);

endmodule

// File: rtl/sample_iterator.sv
// Walks every grid sample of a bounding box in raster order, one per cycle,
// holding the bounding-box stage off while a triangle is being walked.
module sample_iterator
    import sample_iterator_pkg::*;
#(
    parameter int unsigned SIGFIG = 24,
    parameter int unsigned RADIX  = 10,
    parameter int unsigned VERTS  = 3,
    parameter int unsigned AXIS   = 3,
    parameter int unsigned COLORS = 3
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
    input  logic        [COLORS-1:0][SIGFIG-1:0]          color_R13U,
    input  logic signed [1:0][1:0][SIGFIG-1:0]            box_R13S,
    input  logic                                        validTri_R13H,
    input  logic [3:0]                                  subSample_RnnnnU,
    output logic                                        halt_RnnnnL,
    output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
    output logic        [COLORS-1:0][SIGFIG-1:0]          color_R14U,
    output logic signed [1:0][SIGFIG-1:0]                 sample_R14S,
    output logic                                        validSamp_R14H
);

    state_e state_q, state_d;
    logic   valid_q, valid_d;
    logic   load, advance, last;
    logic   [SIGFIG-1:0] step;

    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q;
    logic [COLORS-1:0][SIGFIG-1:0]          color_q;
    logic [1:0][SIGFIG-1:0]                 sample;

    assign step = SIGFIG'(subsample_step(subSample_RnnnnU, RADIX));

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        load    = 1'b0;
        advance = 1'b0;
        unique case (state_q)
            WAIT_STATE: begin
                valid_d = 1'b0;
                if (validTri_R13H) begin
                    load    = 1'b1;
                    valid_d = 1'b1;
                    state_d = TEST_STATE;
                end
            end
            TEST_STATE: begin
                // New triangles are ignored here; upstream is halted.
                advance = 1'b1;
                if (last) begin
                    valid_d = 1'b0;
                    state_d = WAIT_STATE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = WAIT_STATE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= WAIT_STATE;
            valid_q <= 1'b0;
            tri_q   <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            if (load) begin
                tri_q   <= tri_R13S;
                color_q <= color_R13U;
            end
        end
    end

    sample_stepper #(
        .SIGFIG(SIGFIG)
    ) u_stepper (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load),
        .advance_i(advance),
        .box_i    (box_R13S),
        .step_i   (step),
        .sample_o (sample),
        .last_o   (last)
    );

    assign halt_RnnnnL    = (state_q == WAIT_STATE);
    assign validSamp_R14H = valid_q;
    assign tri_R14S       = tri_q;
    assign color_R14U     = color_q;
    assign sample_R14S    = sample;

endmodule

// File: doc/sample_iterator.md
Name: sample_iterator

Overview:
- Upstream neighbour of the jitter/sample-test path.
- Accepts one triangle at a time from the bounding-box stage: triangle, colour, and a bounding box already snapped to the sample grid.
- Walks every sample position in the box in raster order, one per cycle, presenting each sample with its triangle and colour to the jitter stage and then sample test.
- Stalls the bounding-box stage through an active-low halt while a box is being walked.

Parameters:
- SIGFIG, 24, bits in position and colour words
- RADIX, 10, fraction bits in position words
- VERTS, 3, vertices per triangle
- AXIS, 3, axes per vertex (x,y,z)
- COLORS, 3, colour channels

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- tri_R13S  in  SIGFIG x VERTS x AXIS signed  triangle from bbox stage
- color_R13U  in  SIGFIG x COLORS unsigned  triangle colour
- box_R13S  in  SIGFIG x 2 x 2 signed  [0]=lower-left (x,y), [1]=upper-right (x,y); grid-aligned, ll<=ur
- validTri_R13H  in  1  triangle/box valid
- subSample_RnnnnU  in  4  one-hot MSAA mode: 1000=1x, 0100=4x, 0010=16x, 0001=64x; static while any triangle is in flight
- halt_RnnnnL  out  1  low = upstream must hold R13 inputs
- tri_R14S  out  SIGFIG x VERTS x AXIS signed  latched triangle
- color_R14U  out  SIGFIG x COLORS unsigned  latched colour
- sample_R14S  out  SIGFIG x 2 signed  current sample (x,y)
- validSamp_R14H  out  1  sample_R14S valid this cycle

Behaviour:
- Reset (rst low, async):
  - state=WAIT.
  - tri_R14S, color_R14U, sample_R14S = 0.
  - validSamp_R14H = 0; halt_RnnnnL = 1.
- Step size: 1x -> 1<<RADIX; 4x -> 1<<(RADIX-1); 16x -> 1<<(RADIX-2); 64x -> 1<<(RADIX-3). Any non-one-hot value uses the 1x step.
- FSM WAIT:
  - halt_RnnnnL=1, validSamp_R14H=0.
  - On validTri_R13H=1: register tri, colour and box; sample_R14S<=box ll; validSamp_R14H<=1; go to TEST.
- FSM TEST:
  - halt_RnnnnL=0; validSamp_R14H=1; outputs reflect the current sample.
  - Next sample:
    - if x<ur.x: x+=step.
    - else if y<ur.y: x=ll.x, y+=step.
    - else (x==ur.x and y==ur.y): the last sample is presented this cycle; next state WAIT; validSamp_R14H<=0.
- halt_RnnnnL is a registered/state-decoded output with no combinational path from inputs. There is exactly one bubble cycle (WAIT) between consecutive triangles.
- validTri_R13H during TEST is ignored; upstream holds it under halt.
- Degenerate box (ll==ur): exactly one sample, then WAIT.
- Box edges are inclusive on both ends. Sample count = ((ur.x-ll.x)/step+1)*((ur.y-ll.y)/step+1).
- Arithmetic: SIGFIG signed adds. Grid alignment plus ll<=ur guarantees no overflow; no saturation logic.
- tri_R14S and color_R14U hold constant for the whole TEST phase. They retain their last value in WAIT.
- Async reset mid-walk aborts the triangle immediately and returns all outputs to reset values. No partial state survives.
- No downstream backpressure: one sample per cycle unconditionally.

Decomposition:
- Shared raster package:
  - state enum {WAIT_STATE, TEST_STATE}.
  - subsample one-hot encodings.
  - function subsample_step(mode) returning the SIGFIG step.
- One natural sub-module: sample_stepper, holding the x/y counters, end-of-box detect and next-sample arithmetic. The top level holds the FSM, the latches and halt.

Test Plan:
- Reset then idle: rst low mid-cycle -> all outputs 0 immediately, halt_RnnnnL=1. Release with validTri=0 -> validSamp stays 0.
- 1x walk, box ll=(0,0), ur=(2048,1024):
  - expect six consecutive valid samples (0,0),(1024,0),(2048,0),(0,1024),(1024,1024),(2048,1024);
  - halt_RnnnnL low for exactly those 6 cycles;
  - tri/colour constant throughout.
- 4x walk, box ll=(1024,1024), ur=(1536,1536) -> samples (1024,1024),(1536,1024),(1024,1536),(1536,1536), then WAIT.
- Degenerate box ll=ur=(3072,512) -> one sample (3072,512) with validSamp=1 for 1 cycle; halt low 1 cycle.
- Back-to-back triangles, validTri held high with a second triangle queued -> second triangle's first sample appears exactly 2 cycles after the first triangle's last sample (one bubble); first triangle's latched data never corrupted.
- Reset asserted on the 3rd sample of a 6-sample walk -> validSamp=0 and state WAIT at once. After release, the next validTri starts at its own box ll.
